// File: rtl/segment_loader_pkg.sv
// Shared definitions for the segment loader: FSM state encoding and default geometry.
package segment_loader_pkg;

  localparam int DEF_SEG_W   = 4;
  localparam int DEF_NUM_SEG = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } seg_state_t;

endpackage

// File: rtl/segment_loader_therm_mask.sv
// Active-low thermometer encoder: bit i is 0 for i <= k and 1 for i > k.
module therm_mask #(
  parameter int NUM_SEG = 4,
  parameter int ADDR_W  = $clog2(NUM_SEG)
) (
  input  logic [ADDR_W-1:0]  k,
  output logic [NUM_SEG-1:0] mask_n
);

  // Compare every bit position against the address, one extra bit avoids overflow on i.
  always_comb begin
    mask_n = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      mask_n[i] = ({1'b0, k} < (ADDR_W+1)'(i));
    end
  end

endmodule

// File: rtl/segment_loader.sv
// Segment loader: writes SEG_W-bit segments into a NUM_SEG-entry register bank,
// addressed directly or through an auto-incrementing pointer that stops at the top.
//
// state | meaning
// EMPTY | no segment loaded since reset/clr
// FILL  | at least one segment loaded, not all
// FULL  | every segment loaded; auto-mode writes are dropped
module segment_loader
  import segment_loader_pkg::*;
#(
  parameter int SEG_W   = DEF_SEG_W,
  parameter int NUM_SEG = DEF_NUM_SEG,
  parameter int ADDR_W  = $clog2(NUM_SEG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEG_W-1:0]         din,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     wr_en,
  input  logic                     auto_mode,
  input  logic                     clr,
  output logic [NUM_SEG*SEG_W-1:0] dout,
  output logic [NUM_SEG-1:0]       clr_n,
  output logic [NUM_SEG-1:0]       seg_valid,
  output logic                     full,
  output logic [ADDR_W-1:0]        wr_ptr,
  output logic                     overflow
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_SEG - 1);

  seg_state_t state_q, state_d;

  logic [NUM_SEG-1:0][SEG_W-1:0] seg_q;
  logic [NUM_SEG-1:0]            clr_n_q;
  logic [NUM_SEG-1:0]            seg_valid_q;
  logic                          full_q;
  logic [ADDR_W-1:0]             wr_ptr_q;
  logic                          overflow_q;

  logic                          blocked;
  logic                          accept;
  logic                          drop;
  logic [ADDR_W-1:0]             target;
  logic [NUM_SEG-1:0]            hit;
  logic [NUM_SEG-1:0]            valid_after;
  logic [NUM_SEG-1:0]            mask_n;

  therm_mask #(
    .NUM_SEG (NUM_SEG),
    .ADDR_W  (ADDR_W)
  ) u_therm_mask (
    .k      (target),
    .mask_n (mask_n)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // FSM next state: clr always wins; FULL is left only through clr or reset.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = (&valid_after) ? FULL : FILL;
        FILL:    if (&valid_after) state_d = FULL;
        FULL:    state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  // FSM outputs: write target, accept/drop decision and the post-write valid mask.
  always_comb begin
    blocked     = auto_mode && (state_q == FULL);
    target      = auto_mode ? wr_ptr_q : addr;
    accept      = wr_en && !clr && !blocked;
    drop        = wr_en && !clr && blocked;
    hit         = '0;
    if (accept) hit[target] = 1'b1;
    valid_after = seg_valid_q | hit;
  end

  // Segment bank, flags and pointer; clr restores the reset image one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= '0;
      clr_n_q     <= '1;
      seg_valid_q <= '0;
      full_q      <= 1'b0;
      wr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
    end else if (clr) begin
      seg_q       <= '0;
      clr_n_q     <= '1;
      seg_valid_q <= '0;
      full_q      <= 1'b0;
      wr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q  <= drop;
      seg_valid_q <= valid_after;
      full_q      <= &valid_after;
      if (accept) begin
        seg_q[target] <= din;
        clr_n_q       <= mask_n;
        if (auto_mode && (wr_ptr_q != LAST_PTR)) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
    end
  end

  assign dout      = seg_q;
  assign clr_n     = clr_n_q;
  assign seg_valid = seg_valid_q;
  assign full      = full_q;
  assign wr_ptr    = wr_ptr_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_segment_loader.sv
// Bench for segment_loader: a 4x4 and an 8x8 instance share one stimulus stream and are
// checked every cycle against an array model, plus hand-computed literal expectations.
module tb_segment_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic [2:0] addr = '0;
  logic       wr_en = 1'b0;
  logic       auto_mode = 1'b0;
  logic       clr = 1'b0;

  logic [15:0] a_dout;
  logic [3:0]  a_clr_n, a_valid;
  logic        a_full, a_ovf;
  logic [1:0]  a_ptr;

  logic [63:0] b_dout;
  logic [7:0]  b_clr_n, b_valid;
  logic        b_full, b_ovf;
  logic [2:0]  b_ptr;

  int checks = 0;
  int errors = 0;
  bit en = 0;

  int unsigned m_seg[2][16];
  bit          m_val[2][16];
  int          m_ptr[2];
  int          m_last[2];
  bit          m_has[2];
  bit          m_ovf[2];

  always #5 clk = ~clk;

  segment_loader u_a (
    .clk(clk), .rst_n(rst_n), .din(din[3:0]), .addr(addr[1:0]), .wr_en(wr_en),
    .auto_mode(auto_mode), .clr(clr), .dout(a_dout), .clr_n(a_clr_n),
    .seg_valid(a_valid), .full(a_full), .wr_ptr(a_ptr), .overflow(a_ovf)
  );

  segment_loader #(.SEG_W(8), .NUM_SEG(8)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din), .addr(addr), .wr_en(wr_en),
    .auto_mode(auto_mode), .clr(clr), .dout(b_dout), .clr_n(b_clr_n),
    .seg_valid(b_valid), .full(b_full), .wr_ptr(b_ptr), .overflow(b_ovf)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear(int j);
    for (int i = 0; i < 16; i++) begin
      m_seg[j][i] = 0;
      m_val[j][i] = 0;
    end
    m_ptr[j] = 0; m_last[j] = 0; m_has[j] = 0; m_ovf[j] = 0;
  endtask

  task automatic model_step(int j);
    int n; int w; int t; bit f;
    n = j ? 8 : 4;
    w = j ? 8 : 4;
    f = 1;
    for (int i = 0; i < n; i++) if (!m_val[j][i]) f = 0;
    m_ovf[j] = 0;
    if (clr) begin
      model_clear(j);
    end else if (wr_en) begin
      if (auto_mode && f) begin
        m_ovf[j] = 1;
      end else begin
        t = auto_mode ? m_ptr[j] : (int'(addr) % n);
        m_seg[j][t] = int'(din) % (1 << w);
        m_val[j][t] = 1;
        m_last[j] = t;
        m_has[j] = 1;
        if (auto_mode && m_ptr[j] < n - 1) m_ptr[j]++;
      end
    end
  endtask

  task automatic cmp(int j, logic [63:0] d, logic [15:0] cn, logic [15:0] sv,
                     logic fu, logic [3:0] wp, logic ov);
    int n; int w; logic [63:0] e_d; logic [15:0] e_cn; logic [15:0] e_sv; bit f;
    n = j ? 8 : 4;
    w = j ? 8 : 4;
    e_d = '0; e_cn = '0; e_sv = '0; f = 1;
    for (int i = 0; i < n; i++) begin
      e_d = e_d | (64'(m_seg[j][i]) << (i * w));
      e_cn[i] = !(m_has[j] && i <= m_last[j]);
      e_sv[i] = m_val[j][i];
      if (!m_val[j][i]) f = 0;
    end
    chk($sformatf("dout%0d", j), d, e_d);
    chk($sformatf("clr_n%0d", j), 64'(cn), 64'(e_cn));
    chk($sformatf("seg_valid%0d", j), 64'(sv), 64'(e_sv));
    chk($sformatf("full%0d", j), 64'(fu), 64'(f));
    chk($sformatf("wr_ptr%0d", j), 64'(wp), 64'(m_ptr[j]));
    chk($sformatf("overflow%0d", j), 64'(ov), 64'(m_ovf[j]));
  endtask

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (en) begin
      cmp(0, 64'(a_dout), 16'(a_clr_n), 16'(a_valid), a_full, 4'(a_ptr), a_ovf);
      cmp(1, b_dout, 16'(b_clr_n), 16'(b_valid), b_full, 4'(b_ptr), b_ovf);
    end
  end

  task automatic tick(bit we, bit am, logic [2:0] a, logic [7:0] d, bit c);
    wr_en = we; auto_mode = am; addr = a; din = d; clr = c;
    @(posedge clk); #1;
    wr_en = 0; clr = 0;
  endtask

  initial begin
    model_clear(0);
    model_clear(1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 64'(a_dout), 64'h0);
    chk("rst_clr_n", 64'(a_clr_n), 64'hF);
    rst_n = 1'b1;
    en = 1;
    chk("rst_valid", 64'(a_valid), 64'h0);
    chk("rst_full", 64'(a_full), 64'h0);
    chk("rst_ptr", 64'(a_ptr), 64'h0);
    chk("rst_ovf", 64'(a_ovf), 64'h0);

    // auto fill of the 4x4 instance
    tick(1, 1, 0, 8'h01, 0); chk("auto1_clr_n", 64'(a_clr_n), 64'b1110);
    tick(1, 1, 0, 8'h02, 0); chk("auto2_clr_n", 64'(a_clr_n), 64'b1100);
    tick(1, 1, 0, 8'h03, 0); chk("auto3_clr_n", 64'(a_clr_n), 64'b1000);
    chk("auto3_full", 64'(a_full), 64'h0);
    tick(1, 1, 0, 8'h04, 0); chk("auto4_clr_n", 64'(a_clr_n), 64'b0000);
    chk("auto4_dout", 64'(a_dout), 64'h4321);
    chk("auto4_full", 64'(a_full), 64'h1);
    chk("b4_dout", b_dout, 64'h04030201);

    // dropped write while full in auto mode
    tick(1, 1, 0, 8'h0F, 0);
    chk("drop_dout", 64'(a_dout), 64'h4321);
    chk("drop_ovf", 64'(a_ovf), 64'h1);
    tick(0, 1, 0, 8'h00, 0);
    chk("drop_ovf_end", 64'(a_ovf), 64'h0);

    // clr, then clr colliding with a write
    tick(0, 1, 0, 8'h00, 1);
    chk("clr_dout", 64'(a_dout), 64'h0);
    chk("clr_clr_n", 64'(a_clr_n), 64'hF);
    tick(1, 1, 0, 8'h09, 1);
    chk("clrwr_dout", 64'(a_dout), 64'h0);
    chk("clrwr_ovf", 64'(a_ovf), 64'h0);
    chk("clrwr_valid", 64'(a_valid), 64'h0);

    // direct mode
    tick(1, 0, 2, 8'h0A, 0);
    tick(1, 0, 0, 8'h05, 0);
    chk("dir_dout", 64'(a_dout), 64'h0A05);
    chk("dir_clr_n", 64'(a_clr_n), 64'b1110);
    chk("dir_valid", 64'(a_valid), 64'b0101);
    chk("dir_b_dout", b_dout, 64'h000A0005);

    // reset in the middle of an auto sequence
    tick(0, 1, 0, 8'h00, 1);
    tick(1, 1, 0, 8'h01, 0);
    tick(1, 1, 0, 8'h02, 0);
    rst_n = 1'b0;
    #1;
    chk("mrst_dout", 64'(a_dout), 64'h0);
    chk("mrst_ptr", 64'(a_ptr), 64'h0);
    chk("mrst_clr_n", 64'(a_clr_n), 64'hF);
    #1;
    rst_n = 1'b1;
    tick(1, 1, 0, 8'h07, 0);
    chk("mrst_wr_dout", 64'(a_dout), 64'h0007);
    chk("mrst_wr_ptr", 64'(a_ptr), 64'h1);
    chk("mrst_wr_clr_n", 64'(a_clr_n), 64'b1110);

    // 8x8 auto fill and overflow
    tick(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < 8; i++) tick(1, 1, 0, 8'(8'h11 * (i + 1)), 0);
    chk("b_full", 64'(b_full), 64'h1);
    chk("b_ptr", 64'(b_ptr), 64'h7);
    chk("b_dout", b_dout, 64'h8877665544332211);
    chk("a_fill_dout", 64'(a_dout), 64'h4321);
    tick(1, 1, 0, 8'hFF, 0);
    chk("b_ovf", 64'(b_ovf), 64'h1);
    chk("b_ovf_dout", b_dout, 64'h8877665544332211);
    chk("b_ovf_ptr", 64'(b_ptr), 64'h7);
    tick(0, 1, 0, 8'h00, 0);
    chk("b_ovf_end", 64'(b_ovf), 64'h0);

    // mode toggle, then direct overwrite while full
    tick(0, 0, 0, 8'h00, 0);
    chk("tog_ptr", 64'(b_ptr), 64'h7);
    tick(1, 0, 1, 8'h99, 0);
    chk("ovw_dout", 64'(a_dout), 64'h4391);
    chk("ovw_ovf", 64'(a_ovf), 64'h0);
    chk("ovw_full", 64'(a_full), 64'h1);
    chk("ovw_b_dout", b_dout, 64'h8877665544339911);
    tick(0, 1, 0, 8'h00, 0);
    tick(0, 0, 0, 8'h00, 0);

    en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
